// File: rtl/ctrl_axi_pkg.sv
// Shared types for the ctrl-port AXI3 slave: burst/response codes, FSM states
// and a worst-of helper for combining response codes.
package ctrl_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_DATA = 3'd5
    } state_e;

    // Response codes are ordered by severity, so the numerically larger one wins.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_axi_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts of 4-byte beats, plus a flag
// telling whether the burst length is legal for WRAP.
module ctrl_axi_addr_gen
    import ctrl_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr_i,
    input  logic [3:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  wrap_ok_o
);

    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign incr_addr = cur_addr_i + ADDR_WIDTH'(4);
    // Wrap boundary is (len+1)*4 bytes; only valid when len+1 is a power of two.
    assign wrap_mask = ADDR_WIDTH'({len_i, 2'b11});
    assign wrap_ok_o = (len_i == 4'd1) || (len_i == 4'd3) || (len_i == 4'd7) || (len_i == 4'd15);

    always_comb begin
        next_addr_o = cur_addr_i;
        case (burst_i)
            BURST_FIXED: next_addr_o = cur_addr_i;
            BURST_INCR:  next_addr_o = incr_addr;
            BURST_WRAP:  next_addr_o = (cur_addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = cur_addr_i;
        endcase
    end

endmodule

// File: rtl/ctrl_axi_slave.sv
// AXI3 slave burst engine: serialises read/write bursts into single-beat
// register requests and generates all B/R responses, one burst at a time.
module ctrl_axi_slave
    import ctrl_axi_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          ID_WIDTH   = 12,
    parameter logic [ADDR_WIDTH-1:0] BASEADDR  = 32'h6e400000,
    parameter logic [ADDR_WIDTH-1:0] HIGHADDR  = 32'h6e4fffff,
    parameter int unsigned          REG_AW     = 18
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic [ID_WIDTH-1:0]   wid,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_write,
    output logic [REG_AW-1:0]     req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic [3:0]            req_wstrb,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output state_e                dbg_state_o
);

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [3:0]            len_q, len_d;
    logic [1:0]            burst_q, burst_d;
    logic [1:0]            err_q, err_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rr_last_write_q, rr_last_write_d;

    logic                  sel_write, sel_read;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [3:0]            sel_len;
    logic [2:0]            sel_size;
    logic [1:0]            sel_burst;
    logic [3:0]            ag_len;
    logic [1:0]            ag_burst;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  wrap_ok;
    logic [ADDR_WIDTH-1:0] offs;
    logic                  beat_last;
    logic [1:0]            adv_err;
    logic [1:0]            err_w;
    logic                  w_beat;
    logic                  unused_bits;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASEADDR) && (a <= HIGHADDR);
    endfunction

    // Round-robin on simultaneous requests; nothing is accepted while RST is held.
    assign sel_write = !RST && awvalid && (!arvalid || !rr_last_write_q);
    assign sel_read  = !RST && arvalid && (!awvalid || rr_last_write_q);
    assign sel_addr  = sel_write ? awaddr  : araddr;
    assign sel_len   = sel_write ? awlen   : arlen;
    assign sel_size  = sel_write ? awsize  : arsize;
    assign sel_burst = sel_write ? awburst : arburst;

    // In IDLE the generator only judges the incoming burst's WRAP legality.
    assign ag_len   = (state_q == ST_IDLE) ? sel_len   : len_q;
    assign ag_burst = (state_q == ST_IDLE) ? sel_burst : burst_q;

    ctrl_axi_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .cur_addr_i  (cur_addr_q),
        .len_i       (ag_len),
        .burst_i     (ag_burst),
        .next_addr_o (next_addr),
        .wrap_ok_o   (wrap_ok)
    );

    assign offs        = cur_addr_q - BASEADDR;
    assign beat_last   = (cnt_q == len_q);
    assign adv_err     = in_window(next_addr) ? RESP_OKAY : RESP_DECERR;
    assign unused_bits = ^{wid, offs[ADDR_WIDTH-1:REG_AW+2], offs[1:0]};

    assign req_addr    = offs[REG_AW+1:2];
    assign req_wdata   = wdata;
    assign req_wstrb   = wstrb;
    assign bid         = id_q;
    assign rid         = id_q;
    assign bresp       = err_q;
    assign rresp       = err_q;
    assign rdata       = rdata_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_IDLE;
            id_q            <= '0;
            cur_addr_q      <= '0;
            len_q           <= '0;
            burst_q         <= '0;
            err_q           <= RESP_OKAY;
            cnt_q           <= '0;
            rdata_q         <= '0;
            rr_last_write_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            cur_addr_q      <= cur_addr_d;
            len_q           <= len_d;
            burst_q         <= burst_d;
            err_q           <= err_d;
            cnt_q           <= cnt_d;
            rdata_q         <= rdata_d;
            rr_last_write_q <= rr_last_write_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        cur_addr_d      = cur_addr_q;
        len_d           = len_q;
        burst_d         = burst_q;
        err_d           = err_q;
        cnt_d           = cnt_q;
        rdata_d         = rdata_q;
        rr_last_write_d = rr_last_write_q;
        awready         = 1'b0;
        arready         = 1'b0;
        wready          = 1'b0;
        bvalid          = 1'b0;
        rvalid          = 1'b0;
        rlast           = 1'b0;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        err_w           = err_q;
        w_beat          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                awready = sel_write;
                arready = sel_read;
                if (sel_write || sel_read) begin
                    id_d       = sel_write ? awid : arid;
                    cur_addr_d = sel_addr;
                    len_d      = sel_len;
                    burst_d    = sel_burst;
                    cnt_d      = '0;
                    if (!in_window(sel_addr)) begin
                        err_d = RESP_DECERR;
                    end else if ((sel_size != SIZE_4B) || (sel_burst == 2'b11) ||
                                 ((sel_burst == BURST_WRAP) && !wrap_ok)) begin
                        err_d = RESP_SLVERR;
                    end else begin
                        err_d = RESP_OKAY;
                    end
                    state_d = sel_write ? ST_WR_DATA : ST_RD_REQ;
                end
            end

            ST_WR_DATA: begin
                if (err_q == RESP_OKAY) begin
                    req_valid = wvalid;
                    req_write = 1'b1;
                    wready    = req_ready;
                end else begin
                    wready = 1'b1;
                end
                w_beat = wvalid && wready;
                if (w_beat) begin
                    // The beat counter decides where the burst ends; a wrong wlast only taints bresp.
                    if (wlast != beat_last) begin
                        err_w = resp_max(err_q, RESP_SLVERR);
                    end
                    if (beat_last) begin
                        err_d   = err_w;
                        state_d = ST_WR_RESP;
                    end else begin
                        err_d      = resp_max(err_w, adv_err);
                        cnt_d      = cnt_q + 4'd1;
                        cur_addr_d = next_addr;
                    end
                end
            end

            ST_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    rr_last_write_d = 1'b1;
                    state_d         = ST_IDLE;
                end
            end

            ST_RD_REQ: begin
                if (err_q == RESP_OKAY) begin
                    req_valid = 1'b1;
                    if (req_ready) begin
                        state_d = ST_RD_WAIT;
                    end
                end else begin
                    rdata_d = '0;
                    state_d = ST_RD_DATA;
                end
            end

            ST_RD_WAIT: begin
                if (rsp_valid) begin
                    rdata_d = rsp_data;
                    state_d = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                rvalid = 1'b1;
                rlast  = beat_last;
                if (rready) begin
                    if (beat_last) begin
                        rr_last_write_d = 1'b0;
                        state_d         = ST_IDLE;
                    end else begin
                        err_d      = resp_max(err_q, adv_err);
                        cnt_d      = cnt_q + 4'd1;
                        cur_addr_d = next_addr;
                        state_d    = ST_RD_REQ;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctrl_axi_slave.sv
// Directed bench for ctrl_axi_slave: AXI driver tasks, a register-file responder
// returning word_offset*2, and a request scoreboard checked after each burst.
module tb_ctrl_axi_slave;
    import ctrl_axi_pkg::*;

    localparam int W = 55;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [11:0] awid = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic [11:0] wid = '0;
    logic        bvalid, bready = 1'b0;
    logic [11:0] bid;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [11:0] arid = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [11:0] rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        req_valid, req_ready = 1'b1;
    logic        req_write;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    state_e      dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [34:0]  rexp_q[$];
    logic         ord_q[$];
    logic         ord_exp_q[$];

    bit          stall_en = 1'b0;
    int unsigned cyc = 0;
    int unsigned pend_cnt = 0;
    int unsigned pend_done = 0;
    logic [17:0] pend_addr = '0;

    ctrl_axi_slave dut (
        .CLK(CLK), .RST(RST),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
        .rresp(rresp), .rlast(rlast),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Register-file responder: one rsp pulse the cycle after each read request
    always @(posedge CLK) begin
        #1;
        cyc = cyc + 1;
        req_ready = stall_en ? cyc[0] : 1'b1;
        rsp_valid = (pend_cnt != pend_done);
        rsp_data  = {13'h0, pend_addr, 1'b0};
        pend_done = pend_cnt;
    end

    // Monitor: inputs only change at posedge+1, so the negedge sees the edge's values
    always @(negedge CLK) begin
        if (!RST && req_valid && req_ready) begin
            got_q.push_back({req_write, req_addr,
                             req_write ? req_wdata : 32'h0,
                             req_write ? req_wstrb : 4'h0});
            if (!req_write) begin
                pend_cnt  = pend_cnt + 1;
                pend_addr = req_addr;
            end
        end
        if (!RST && awvalid && awready) ord_q.push_back(1'b1);
        if (!RST && arvalid && arready) ord_q.push_back(1'b0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_w(input logic [17:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back({1'b1, a, d, s});
    endtask

    task automatic push_rq(input logic [17:0] a);
        exp_q.push_back({1'b0, a, 32'h0, 4'h0});
    endtask

    task automatic push_beat(input logic last, input logic [1:0] resp, input logic [31:0] d);
        rexp_q.push_back({last, resp, d});
    endtask

    task automatic check_reqs(input string tag);
        check({tag, "_nreq"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_req"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [31:0] dbase,
                             input logic [3:0] strb, input bit bad_wlast, input logic [1:0] exp_resp);
        int t;
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
        t = 0;
        @(negedge CLK);
        while (!awready && t < 200) begin @(negedge CLK); t++; end
        check("aw_hs", 64'(awready), 64'd1);
        if (!awready) begin awvalid = 1'b0; return; end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = dbase + 32'(i); wstrb = strb; wid = id;
            wlast  = bad_wlast ? 1'b0 : (i == int'(len));
            t = 0;
            @(negedge CLK);
            while (!wready && t < 200) begin @(negedge CLK); t++; end
            check("w_hs", 64'(wready), 64'd1);
            if (!wready) begin wvalid = 1'b0; return; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!bvalid && t < 200) begin @(negedge CLK); t++; end
        check("b_hs", 64'(bvalid), 64'd1);
        check("bid", 64'(bid), 64'(id));
        check("bresp", 64'(bresp), 64'(exp_resp));
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int hold);
        int t;
        logic [34:0] e;
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
        t = 0;
        @(negedge CLK);
        while (!arready && t < 200) begin @(negedge CLK); t++; end
        check("ar_hs", 64'(arready), 64'd1);
        if (!arready) begin arvalid = 1'b0; return; end
        tick();
        arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            e = (rexp_q.size() > 0) ? rexp_q.pop_front() : 35'h0;
            rready = !(i == 0 && hold > 0);
            t = 0;
            @(negedge CLK);
            while (!rvalid && t < 200) begin @(negedge CLK); t++; end
            check("r_hs", 64'(rvalid), 64'd1);
            if (!rvalid) begin rready = 1'b0; return; end
            if (i == 0 && hold > 0) begin
                for (int h = 0; h < hold; h++) begin
                    tick();
                    @(negedge CLK);
                    check("hold_rvalid", 64'(rvalid), 64'd1);
                    check("hold_rdata", 64'(rdata), 64'(e[31:0]));
                end
                tick();
                rready = 1'b1;
                @(negedge CLK);
            end
            check("rdata", 64'(rdata), 64'(e[31:0]));
            check("rresp", 64'(rresp), 64'(e[33:32]));
            check("rlast", 64'(rlast), 64'(e[34]));
            check("rid", 64'(rid), 64'(id));
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, 64'(awready), 64'd0);
        check({tag, "_arready"}, 64'(arready), 64'd0);
        check({tag, "_wready"}, 64'(wready), 64'd0);
        check({tag, "_bvalid"}, 64'(bvalid), 64'd0);
        check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        check({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        check({tag, "_rdata"}, 64'(rdata), 64'd0);
        check({tag, "_rid"}, 64'(rid), 64'd0);
        check({tag, "_bid"}, 64'(bid), 64'd0);
        check({tag, "_rresp"}, 64'(rresp), 64'd0);
        check({tag, "_bresp"}, 64'(bresp), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    initial begin
        // Reset, with both address channels requesting: nothing may be accepted
        RST = 1'b1;
        awvalid = 1'b1; arvalid = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        check_idle_outputs("reset");
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        RST = 1'b0;
        tick();

        // Simultaneous AW/AR after reset: write first, then alternation
        push_w(18'h8, 32'h11110000, 4'hf);
        push_rq(18'h9);
        push_beat(1'b1, RESP_OKAY, 32'h12);
        ord_exp_q.push_back(1'b1); ord_exp_q.push_back(1'b0);
        fork
            axi_write(32'h6e400020, 12'h0a1, 4'd0, 3'b010, BURST_INCR, 32'h11110000, 4'hf, 1'b0, RESP_OKAY);
            axi_read(32'h6e400024, 12'h0b2, 4'd0, 3'b010, BURST_INCR, 0);
        join
        check_reqs("arb1");
        push_w(18'h10, 32'h22220000, 4'hf);
        ord_exp_q.push_back(1'b1);
        axi_write(32'h6e400040, 12'h0c3, 4'd0, 3'b010, BURST_INCR, 32'h22220000, 4'hf, 1'b0, RESP_OKAY);
        check_reqs("arb_single");
        push_rq(18'h12);
        push_w(18'h11, 32'h33330000, 4'hf);
        push_beat(1'b1, RESP_OKAY, 32'h24);
        ord_exp_q.push_back(1'b0); ord_exp_q.push_back(1'b1);
        fork
            axi_write(32'h6e400044, 12'h0d4, 4'd0, 3'b010, BURST_INCR, 32'h33330000, 4'hf, 1'b0, RESP_OKAY);
            axi_read(32'h6e400048, 12'h0e5, 4'd0, 3'b010, BURST_INCR, 0);
        join
        check_reqs("arb2");
        check("order_len", 64'(ord_q.size()), 64'(ord_exp_q.size()));
        while (ord_q.size() > 0 && ord_exp_q.size() > 0)
            check("order", 64'(ord_q.pop_front()), 64'(ord_exp_q.pop_front()));

        // Single write and INCR read with a stalling register port
        stall_en = 1'b1;
        push_w(18'h4, 32'hdeadd00d, 4'hf);
        axi_write(32'h6e400010, 12'h123, 4'd0, 3'b010, BURST_INCR, 32'hdeadd00d, 4'hf, 1'b0, RESP_OKAY);
        check_reqs("single_wr");
        for (int i = 0; i < 4; i++) push_rq(18'(i));
        push_beat(1'b0, RESP_OKAY, 32'h0);
        push_beat(1'b0, RESP_OKAY, 32'h2);
        push_beat(1'b0, RESP_OKAY, 32'h4);
        push_beat(1'b1, RESP_OKAY, 32'h6);
        axi_read(32'h6e400000, 12'h321, 4'd3, 3'b010, BURST_INCR, 0);
        check_reqs("incr_rd");
        for (int i = 0; i < 4; i++) push_w(18'h40 + 18'(i), 32'hcafe0000 + 32'(i), 4'h3);
        axi_write(32'h6e400100, 12'h044, 4'd3, 3'b010, BURST_INCR, 32'hcafe0000, 4'h3, 1'b0, RESP_OKAY);
        check_reqs("incr_wr");
        stall_en = 1'b0;

        // Out of window: drained write, zero-data read
        axi_write(32'h6e500000, 12'h011, 4'd1, 3'b010, BURST_INCR, 32'h0, 4'hf, 1'b0, RESP_DECERR);
        check_reqs("oow_wr");
        push_beat(1'b0, RESP_DECERR, 32'h0);
        push_beat(1'b1, RESP_DECERR, 32'h0);
        axi_read(32'h6e500000, 12'h012, 4'd1, 3'b010, BURST_INCR, 0);
        check_reqs("oow_rd");

        // WRAP read from the top word of a 16-byte block
        push_rq(18'h3); push_rq(18'h0); push_rq(18'h1); push_rq(18'h2);
        push_beat(1'b0, RESP_OKAY, 32'h6);
        push_beat(1'b0, RESP_OKAY, 32'h0);
        push_beat(1'b0, RESP_OKAY, 32'h2);
        push_beat(1'b1, RESP_OKAY, 32'h4);
        axi_read(32'h6e40000c, 12'h077, 4'd3, 3'b010, BURST_WRAP, 0);
        check_reqs("wrap_rd");

        // Unsupported size, illegal WRAP length, reserved burst type
        push_beat(1'b1, RESP_SLVERR, 32'h0);
        axi_read(32'h6e400000, 12'h101, 4'd0, 3'b001, BURST_INCR, 0);
        check_reqs("bad_size");
        axi_write(32'h6e400000, 12'h055, 4'd2, 3'b010, BURST_WRAP, 32'h0, 4'hf, 1'b0, RESP_SLVERR);
        check_reqs("bad_wrap");
        push_beat(1'b1, RESP_SLVERR, 32'h0);
        axi_read(32'h6e400000, 12'h066, 4'd0, 3'b010, 2'b11, 0);
        check_reqs("rsvd_burst");

        // INCR bursts running past the top of the window
        push_w(18'h3fffe, 32'hbeef0000, 4'hf);
        push_w(18'h3ffff, 32'hbeef0001, 4'hf);
        axi_write(32'h6e4ffff8, 12'h0aa, 4'd3, 3'b010, BURST_INCR, 32'hbeef0000, 4'hf, 1'b0, RESP_DECERR);
        check_reqs("cross_wr");
        push_rq(18'h3ffff);
        push_beat(1'b0, RESP_OKAY, 32'h7fffe);
        push_beat(1'b1, RESP_DECERR, 32'h0);
        axi_read(32'h6e4ffffc, 12'h0bb, 4'd1, 3'b010, BURST_INCR, 0);
        check_reqs("cross_rd");

        // Missing wlast: both beats issued, bresp SLVERR
        push_w(18'h80, 32'h55550000, 4'hf);
        push_w(18'h81, 32'h55550001, 4'hf);
        axi_write(32'h6e400200, 12'h0cc, 4'd1, 3'b010, BURST_INCR, 32'h55550000, 4'hf, 1'b1, RESP_SLVERR);
        check_reqs("wlast_err");

        // FIXED read hits the same register twice
        push_rq(18'hc0); push_rq(18'hc0);
        push_beat(1'b0, RESP_OKAY, 32'h180);
        push_beat(1'b1, RESP_OKAY, 32'h180);
        axi_read(32'h6e400300, 12'h0dd, 4'd1, 3'b010, BURST_FIXED, 0);
        check_reqs("fixed_rd");

        // R backpressure: first beat held for 5 cycles
        push_rq(18'h2); push_rq(18'h3);
        push_beat(1'b0, RESP_OKAY, 32'h4);
        push_beat(1'b1, RESP_OKAY, 32'h6);
        axi_read(32'h6e400008, 12'h0ee, 4'd1, 3'b010, BURST_INCR, 5);
        check_reqs("bp_rd");

        // Reset in the middle of a read burst
        arvalid = 1'b1; araddr = 32'h6e400040; arid = 12'h099; arlen = 4'd7;
        arsize = 3'b010; arburst = BURST_INCR;
        begin
            int t;
            t = 0;
            @(negedge CLK);
            while (!arready && t < 200) begin @(negedge CLK); t++; end
            check("mid_ar_hs", 64'(arready), 64'd1);
        end
        tick();
        arvalid = 1'b0;
        repeat (4) tick();
        @(negedge CLK);
        check("mid_rvalid_pre", 64'(rvalid), 64'd1);
        tick();
        RST = 1'b1;
        tick();
        @(negedge CLK);
        check_idle_outputs("mid_rst");
        tick();
        RST = 1'b0;
        tick();
        got_q.delete();
        exp_q.delete();

        // Fresh traffic after the abandoned burst
        push_w(18'h4, 32'h12345678, 4'hc);
        axi_write(32'h6e400010, 12'h5a5, 4'd0, 3'b010, BURST_INCR, 32'h12345678, 4'hc, 1'b0, RESP_OKAY);
        check_reqs("post_rst_wr");
        push_rq(18'h4);
        push_beat(1'b1, RESP_OKAY, 32'h8);
        axi_read(32'h6e400010, 12'h5a6, 4'd0, 3'b010, BURST_INCR, 0);
        check_reqs("post_rst_rd");

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
